// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-enabled word array with configurable read latency,
// single-cycle ack pulse and stall back-pressure toward the memory stage.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_ack,
    output logic        data_sram_stall
);

    typedef enum logic {
        IDLE,
        RBUSY
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic [31:0]             mem_q [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    accept;
    logic                    is_store;
    logic                    stall;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the array; byte offset is ignored.
    assign req_idx          = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};
    assign accept           = data_sram_en && !stall;
    assign is_store         = |data_sram_wen;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !is_store && (LATENCY > 1)) state_d = RBUSY;
            RBUSY:   if (cnt_q == 2'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall = (state_q == RBUSY);
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                if (is_store) begin
                    ack_d = 1'b1;
                end else if (LATENCY == 1) begin
                    rdata_d = mem_q[req_idx];
                    ack_d   = 1'b1;
                end else begin
                    idx_d = req_idx;
                    cnt_d = CNT_LOAD;
                end
            end
        end else begin
            // The edge that takes cnt to zero completes the read.
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                rdata_d = mem_q[idx_q];
                ack_d   = 1'b1;
            end
        end
    end

    // Array is deliberately left out of reset so stored data survives it.
    always_ff @(posedge clk) begin
        if (resetn && accept && is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem_q[req_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign data_sram_ack   = ack_q;
    assign data_sram_stall = stall;

endmodule
